// File: rtl/aes_pkg.sv
// aes_pkg: key-length encodings, FSM states, S-box and xtime helpers for the key schedule engine
package aes_pkg;
   localparam logic [1:0] LEN_128 = 2'd0;
   localparam logic [1:0] LEN_192 = 2'd1;
   localparam logic [1:0] LEN_256 = 2'd2;
   localparam logic [1:0] LEN_BAD = 2'd3;
   localparam int MAX_WORDS = 60;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_EXPAND = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   function automatic logic [3:0] nk_of(input logic [1:0] len);
      return len == LEN_256 ? 4'd8 : len == LEN_192 ? 4'd6 : 4'd4;
   endfunction
   function automatic logic [3:0] nr_of(input logic [1:0] len);
      return len == LEN_256 ? 4'd14 : len == LEN_192 ? 4'd12 : 4'd10;
   endfunction
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[11'd2047 - {x, 3'b000} -: 8];
   endfunction
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: byte-wise S-box substitution of a 32-bit word
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);
   for (genvar b = 0; b < 4; b++) begin : g_sbox
      assign sub[8*b +: 8] = sbox(word[8*b +: 8]);
   end
endmodule

// File: rtl/aes_key_schedule_engine.sv
// aes_key_schedule_engine: iterative AES-128/192/256 key expansion into a register store with round-key reads
module aes_key_schedule_engine
   import aes_pkg::*;
#(
   parameter int MAX_ROUNDS = 14,
   parameter int KEY_W      = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid_in,
   output logic             key_ready,
   input  logic [1:0]       key_len,
   input  logic [KEY_W-1:0] key,
   output logic             busy,
   output logic             done,
   output logic             sched_valid,
   output logic             err,
   input  logic [3:0]       rk_idx,
   output logic [127:0]     rk_data,
   output logic             rk_valid
);
   localparam int WORDS = 4 * (MAX_ROUNDS + 1);
   logic [1:0]       state;
   logic [KEY_W-1:0] key_r;
   logic [3:0]       nk, nr;
   logic [5:0]       i, base;
   logic [2:0]       p;
   logic [7:0]       rcon;
   logic             done_r, err_r, accept, bad, last;
   logic [31:0]      prev, back, sub_in, sub_out, temp;
   logic [31:0]      w [WORDS];
   assign key_ready   = state == ST_IDLE || state == ST_DONE;
   assign busy        = state == ST_LOAD || state == ST_EXPAND;
   assign sched_valid = state == ST_DONE;
   assign done        = done_r;
   assign err         = err_r;
   assign accept      = key_valid_in && key_ready && key_len != LEN_BAD;
   assign bad         = key_valid_in && key_ready && key_len == LEN_BAD;
   assign prev        = w[i - 6'd1];
   assign back        = w[i - {2'b00, nk}];
   // one S-box bank serves both the RotWord step and the AES-256 mid-block SubWord
   assign sub_in      = p == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
   aes_sub_word u_sub (.word(sub_in), .sub(sub_out));
   assign temp        = p == 3'd0 ? sub_out ^ {rcon, 24'h0} : (nk == 4'd8 && p == 3'd4) ? sub_out : prev;
   assign last        = i == {nr, 2'b11};
   assign base        = rk_idx > MAX_ROUNDS ? 6'd0 : {rk_idx, 2'b00};
   assign rk_data     = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
   assign rk_valid    = sched_valid && rk_idx <= nr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         key_r  <= '0;
         nk     <= 4'd4;
         nr     <= 4'd10;
         i      <= '0;
         p      <= '0;
         rcon   <= '0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         done_r <= state == ST_EXPAND && last;
         err_r  <= bad;
         if (accept) begin
            state <= ST_LOAD;
            key_r <= key;
            nk    <= nk_of(key_len);
            nr    <= nr_of(key_len);
         end else if (state == ST_LOAD) begin
            state <= ST_EXPAND;
            i     <= {2'b00, nk};
            p     <= '0;
            rcon  <= 8'h01;
         end else if (state == ST_EXPAND) begin
            i <= i + 6'd1;
            p <= p == 3'(nk - 4'd1) ? 3'd0 : p + 3'd1;
            if (p == 3'd0) rcon <= xtime(rcon);
            if (last) state <= ST_DONE;
         end
      end
   end
   // the store itself is never reset; contents are only trusted while sched_valid
   always_ff @(posedge clk) begin
      if (state == ST_LOAD) begin
         for (int j = 0; j < 8; j++)
            if (j < int'(nk)) w[j] <= key_r[KEY_W-1-32*j -: 32];
      end else if (state == ST_EXPAND) begin
         w[i] <= back ^ temp;
      end
   end
endmodule
